// File: rtl/axi_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_responder: AXI3 slave backed by a word-addressed memory array.  |
// | Optional: AXI_RESP_ERR_EN (SLVERR on out-of-range beats).  Rev 1.0       |
// +--------------------------------------------------------------------------+
module axi_sram_responder #(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter int          RD_DELAY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic [1:0]  axi_arlock,
  input  logic [3:0]  axi_arcache,
  input  logic [2:0]  axi_arprot,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic [1:0]  axi_awlock,
  input  logic [3:0]  axi_awcache,
  input  logic [2:0]  axi_awprot,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [3:0]  axi_wid,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int         c_AW       = $clog2(MEM_WORDS);
  localparam logic [1:0] c_OKAY     = 2'b00;
  localparam logic [1:0] c_SLVERR   = 2'b10;
  localparam logic [7:0] c_RD_DELAY = 8'(RD_DELAY);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

  logic [31:0] r_mem [MEM_WORDS];

  rd_state_t   r_rstate;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen, r_rbeat, r_rcnt;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [31:0] w_rnext;

  wr_state_t   r_wstate;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen, r_wbeat;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic        r_werr;
  logic        w_wr_fire;
  logic        w_wbeat_err;

  logic w_unused;
  assign w_unused = ^{axi_arlock, axi_arcache, axi_arprot, axi_awlock,
                      axi_awcache, axi_awprot, axi_wid, axi_wlast};

  // Oversized beats behave as 32-bit; WRAP on an illegal length degrades to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [1:0]  s;
    logic [31:0] inc, mask;
    s    = (size > 3'd2) ? 2'd2 : size[1:0];
    inc  = 32'd1 << s;
    mask = ((32'(len) + 32'd1) << s) - 32'd1;
    if (burst == 2'b00)
      return a;
    else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (a & ~mask) | ((a + inc) & mask);
    else
      return a + inc;
  endfunction

  function automatic logic [c_AW-1:0] word_idx(input logic [31:0] a);
    return c_AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_RESP_ERR_EN
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (off >> (c_AW + 2)) == 32'd0;
  endfunction
`endif

  function automatic logic [31:0] read_word(input logic [31:0] a);
`ifdef AXI_RESP_ERR_EN
    if (!in_range(a)) return 32'd0;
`endif
    return r_mem[word_idx(a)];
  endfunction

  function automatic logic [1:0] read_resp(input logic [31:0] a);
`ifdef AXI_RESP_ERR_EN
    return in_range(a) ? c_OKAY : c_SLVERR;
`else
    return (a == a) ? c_OKAY : c_SLVERR;
`endif
  endfunction

  assign w_rnext = next_addr(r_raddr, r_rsize, r_rlen, r_rburst);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rstate    <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rid     <= 4'd0;
      axi_rdata   <= 32'd0;
      axi_rresp   <= c_OKAY;
      axi_rlast   <= 1'b0;
      axi_rvalid  <= 1'b0;
      r_raddr     <= 32'd0;
      r_rlen      <= 8'd0;
      r_rbeat     <= 8'd0;
      r_rcnt      <= 8'd0;
      r_rsize     <= 3'd0;
      r_rburst    <= 2'd0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          axi_arready <= 1'b1;
          if (axi_arvalid && axi_arready) begin
            axi_arready <= 1'b0;
            axi_rid     <= axi_arid;
            r_raddr     <= axi_araddr;
            r_rlen      <= axi_arlen;
            r_rsize     <= axi_arsize;
            r_rburst    <= axi_arburst;
            r_rbeat     <= 8'd0;
            r_rcnt      <= c_RD_DELAY;
            r_rstate    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt != 8'd0) begin
            r_rcnt <= r_rcnt - 8'd1;
          end else begin
            axi_rdata  <= read_word(r_raddr);
            axi_rresp  <= read_resp(r_raddr);
            axi_rlast  <= (r_rlen == 8'd0);
            axi_rvalid <= 1'b1;
            r_rstate   <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            if (axi_rlast) begin
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              axi_arready <= 1'b1;
              r_rstate    <= R_IDLE;
            end else begin
              r_raddr   <= w_rnext;
              r_rbeat   <= r_rbeat + 8'd1;
              axi_rdata <= read_word(w_rnext);
              axi_rresp <= read_resp(w_rnext);
              axi_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign w_wr_fire = (r_wstate == W_DATA) && axi_wvalid && axi_wready;
`ifdef AXI_RESP_ERR_EN
  assign w_wbeat_err = !in_range(r_waddr);
`else
  assign w_wbeat_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wstate    <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bid     <= 4'd0;
      axi_bresp   <= c_OKAY;
      axi_bvalid  <= 1'b0;
      r_waddr     <= 32'd0;
      r_wlen      <= 8'd0;
      r_wbeat     <= 8'd0;
      r_wsize     <= 3'd0;
      r_wburst    <= 2'd0;
      r_werr      <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          axi_awready <= 1'b1;
          if (axi_awvalid && axi_awready) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            axi_bid     <= axi_awid;
            r_waddr     <= axi_awaddr;
            r_wlen      <= axi_awlen;
            r_wsize     <= axi_awsize;
            r_wburst    <= axi_awburst;
            r_wbeat     <= 8'd0;
            r_werr      <= 1'b0;
            r_wstate    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wr_fire) begin
            r_waddr <= next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
            r_wbeat <= r_wbeat + 8'd1;
            r_werr  <= r_werr | w_wbeat_err;
            // Beat count alone ends the burst; wlast is not trusted.
            if (r_wbeat == r_wlen) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= (r_werr || w_wbeat_err) ? c_SLVERR : c_OKAY;
              r_wstate   <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_bresp   <= c_OKAY;
            axi_awready <= 1'b1;
            r_wstate    <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (w_wr_fire && !w_wbeat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) r_mem[word_idx(r_waddr)][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_axi_sram_responder: directed self-checking bench for the AXI SRAM.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_axi_sram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  axi_arid = '0;
  logic [31:0] axi_araddr = '0;
  logic [7:0]  axi_arlen = '0;
  logic [2:0]  axi_arsize = '0;
  logic [1:0]  axi_arburst = '0;
  logic [1:0]  axi_arlock = '0;
  logic [3:0]  axi_arcache = '0;
  logic [2:0]  axi_arprot = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [3:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid;
  logic        axi_rready = 1'b0;
  logic [3:0]  axi_awid = '0;
  logic [31:0] axi_awaddr = '0;
  logic [7:0]  axi_awlen = '0;
  logic [2:0]  axi_awsize = '0;
  logic [1:0]  axi_awburst = '0;
  logic [1:0]  axi_awlock = '0;
  logic [3:0]  axi_awcache = '0;
  logic [2:0]  axi_awprot = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [3:0]  axi_wid = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wlast = 1'b0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] c_FIXED = 2'b00;
  localparam logic [1:0] c_INCR  = 2'b01;
  localparam logic [1:0] c_WRAP  = 2'b10;

  always #5 clock = ~clock;

  axi_sram_responder dut (
    .clock(clock), .reset(reset),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
    .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rid(axi_rid), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wid(axi_wid),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bid(axi_bid),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = 3'd2;
    axi_awburst = burst; axi_awvalid = 1'b1;
    while (!axi_awready && n < 50) begin tick(); n++; end
    check("aw_timeout", 32'(n < 50), 32'd1);
    tick();
    axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    axi_wdata = data; axi_wstrb = strb; axi_wvalid = 1'b1;
    while (!axi_wready && n < 50) begin tick(); n++; end
    check("w_timeout", 32'(n < 50), 32'd1);
    tick();
    axi_wvalid = 1'b0;
  endtask

  task automatic b_resp(input logic [3:0] id);
    int n;
    n = 0;
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 50) begin tick(); n++; end
    check("b_timeout", 32'(n < 50), 32'd1);
    check("bid", 32'(axi_bid), 32'(id));
    check("bresp", 32'(axi_bresp), 32'd0);
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = 3'd2;
    axi_arburst = burst; axi_arvalid = 1'b1;
    while (!axi_arready && n < 50) begin tick(); n++; end
    check("ar_timeout", 32'(n < 50), 32'd1);
    tick();
    axi_arvalid = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                        input logic last, input logic [1:0] resp);
    int n;
    n = 0;
    axi_rready = 1'b1;
    while (!axi_rvalid && n < 50) begin tick(); n++; end
    check({tag, "_timeout"}, 32'(n < 50), 32'd1);
    check({tag, "_data"}, axi_rdata, data);
    check({tag, "_last"}, 32'(axi_rlast), 32'(last));
    check({tag, "_rid"}, 32'(axi_rid), 32'(id));
    check({tag, "_resp"}, 32'(axi_rresp), 32'(resp));
    tick();
    axi_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    check("rst_arready", 32'(axi_arready), 32'd0);
    check("rst_awready", 32'(axi_awready), 32'd0);
    check("rst_wready", 32'(axi_wready), 32'd0);
    check("rst_rvalid", 32'(axi_rvalid), 32'd0);
    check("rst_bvalid", 32'(axi_bvalid), 32'd0);
    reset = 1'b0;
    check("rel_arready0", 32'(axi_arready), 32'd0);
    tick();
    check("rel_arready1", 32'(axi_arready), 32'd1);
    check("rel_awready1", 32'(axi_awready), 32'd1);
    check("rel_wready", 32'(axi_wready), 32'd0);

    // Single write then read with exact latency
    aw_req(4'd1, 32'h1c00_0010, 8'd0, c_INCR);
    w_beat(32'hdead_beef, 4'hf);
    b_resp(4'd1);
    axi_arid = 4'd1; axi_araddr = 32'h1c00_0010; axi_arlen = 8'd0;
    axi_arsize = 3'd2; axi_arburst = c_INCR; axi_arvalid = 1'b1;
    check("lat_arready", 32'(axi_arready), 32'd1);
    tick();
    axi_arvalid = 1'b0;
    check("lat_rvalid0", 32'(axi_rvalid), 32'd0);
    tick();
    check("lat_rvalid1", 32'(axi_rvalid), 32'd0);
    tick();
    check("lat_rvalid2", 32'(axi_rvalid), 32'd1);
    check("lat_rdata", axi_rdata, 32'hdead_beef);
    check("lat_rlast", 32'(axi_rlast), 32'd1);
    check("lat_rresp", 32'(axi_rresp), 32'd0);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("lat_arready_back", 32'(axi_arready), 32'd1);
    check("lat_rvalid_done", 32'(axi_rvalid), 32'd0);

    // INCR burst write 1..4, read back with rready toggling
    aw_req(4'd2, 32'h1c00_0000, 8'd3, c_INCR);
    for (int k = 1; k <= 4; k++) w_beat(32'(k), 4'hf);
    b_resp(4'd2);
    ar_req(4'd2, 32'h1c00_0000, 8'd3, c_INCR);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!axi_rvalid && n < 50) begin tick(); n++; end
      check("incr_timeout", 32'(n < 50), 32'd1);
      check("incr_data", axi_rdata, 32'(k + 1));
      check("incr_last", 32'(axi_rlast), 32'(k == 3));
      tick();
      check("incr_hold_valid", 32'(axi_rvalid), 32'd1);
      check("incr_hold_data", axi_rdata, 32'(k + 1));
      axi_rready = 1'b1;
      tick();
      axi_rready = 1'b0;
    end
    check("incr_rvalid_done", 32'(axi_rvalid), 32'd0);

    // WRAP read starting mid-window
    aw_req(4'd3, 32'h1c00_0000, 8'd3, c_INCR);
    for (int k = 0; k < 4; k++) w_beat(32'h10 + 32'(k), 4'hf);
    b_resp(4'd3);
    ar_req(4'd3, 32'h1c00_0008, 8'd3, c_WRAP);
    r_beat("wrap0", 4'd3, 32'h12, 1'b0, 2'b00);
    r_beat("wrap1", 4'd3, 32'h13, 1'b0, 2'b00);
    r_beat("wrap2", 4'd3, 32'h10, 1'b0, 2'b00);
    r_beat("wrap3", 4'd3, 32'h11, 1'b1, 2'b00);

    // Byte strobes
    aw_req(4'd4, 32'h1c00_0020, 8'd0, c_INCR);
    w_beat(32'haabb_ccdd, 4'hf);
    b_resp(4'd4);
    aw_req(4'd4, 32'h1c00_0020, 8'd0, c_INCR);
    w_beat(32'h1122_3344, 4'b0101);
    b_resp(4'd4);
    ar_req(4'd4, 32'h1c00_0020, 8'd0, c_INCR);
    r_beat("strb", 4'd4, 32'haa22_cc44, 1'b1, 2'b00);

    // FIXED burst repeats one word
    ar_req(4'd6, 32'h1c00_0020, 8'd1, c_FIXED);
    r_beat("fixed0", 4'd6, 32'haa22_cc44, 1'b0, 2'b00);
    r_beat("fixed1", 4'd6, 32'haa22_cc44, 1'b1, 2'b00);

    // Concurrent AR and AW in one cycle, B held under back-pressure
    axi_arid = 4'd3; axi_araddr = 32'h1c00_0020; axi_arlen = 8'd0;
    axi_arsize = 3'd2; axi_arburst = c_INCR; axi_arvalid = 1'b1;
    axi_awid = 4'd5; axi_awaddr = 32'h1c00_0030; axi_awlen = 8'd0;
    axi_awsize = 3'd2; axi_awburst = c_INCR; axi_awvalid = 1'b1;
    check("conc_arready_pre", 32'(axi_arready), 32'd1);
    check("conc_awready_pre", 32'(axi_awready), 32'd1);
    tick();
    axi_arvalid = 1'b0; axi_awvalid = 1'b0;
    check("conc_arready_post", 32'(axi_arready), 32'd0);
    check("conc_awready_post", 32'(axi_awready), 32'd0);
    w_beat(32'h0000_0055, 4'hf);
    n = 0;
    while (!axi_bvalid && n < 50) begin tick(); n++; end
    check("conc_b_timeout", 32'(n < 50), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("conc_bvalid_hold", 32'(axi_bvalid), 32'd1);
      check("conc_bid_hold", 32'(axi_bid), 32'd5);
      tick();
    end
    b_resp(4'd5);
    r_beat("conc_r", 4'd3, 32'haa22_cc44, 1'b1, 2'b00);
    ar_req(4'd5, 32'h1c00_0030, 8'd0, c_INCR);
    r_beat("conc_wr_back", 4'd5, 32'h0000_0055, 1'b1, 2'b00);

    // Reset in the middle of a read burst
    ar_req(4'd7, 32'h1c00_0000, 8'd3, c_INCR);
    r_beat("rstmid0", 4'd7, 32'h10, 1'b0, 2'b00);
    check("rstmid_valid_pre", 32'(axi_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_rvalid", 32'(axi_rvalid), 32'd0);
    check("rstmid_arready", 32'(axi_arready), 32'd0);
    tick(); tick();
    reset = 1'b0;
    check("rstmid_arready_rel", 32'(axi_arready), 32'd0);
    tick();
    check("rstmid_arready_up", 32'(axi_arready), 32'd1);
    ar_req(4'd2, 32'h1c00_0010, 8'd0, c_INCR);
    r_beat("rstmid_new", 4'd2, 32'hdead_beef, 1'b1, 2'b00);

`ifdef AXI_RESP_ERR_EN
    ar_req(4'd9, 32'h0000_0000, 8'd0, c_INCR);
    r_beat("err_rd", 4'd9, 32'h0, 1'b1, 2'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
